gun_hit_detect: RTL

GUN_HIT_DETECT -- requirements
Module: gun_hit_detect

---
 rtl/gun_pkg.sv | 23 ++
 rtl/gun_debounce.sv | 71 +++++++
 rtl/gun_hit_detect.sv | 125 ++++++++++++
 3 files changed

// File: rtl/gun_pkg.sv
// ------------------------------------------------------------------
// gun_pkg: shared FSM state type and default timing for gun_hit_detect.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package gun_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    BLACK      = 3'd2,
    TARGET     = 3'd3,
    RESULT     = 3'd4
  } gun_state_e;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 65000;
  localparam int HIT_MIN_CYCLES_DEFAULT  = 1000;
  localparam int PD_CNT_W                = 16;

endpackage

`default_nettype wire

// File: rtl/gun_debounce.sv
// ------------------------------------------------------------------
// gun_debounce: trigger synchronizer + level debouncer with rise pulse.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module gun_debounce
  import gun_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic rise_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [1:0]       fill_q;
  logic             armed_q, armed_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_w;
  logic             done_w;

  assign sync_w = sync_q[1];
  assign done_w = (sync_w != level_q) && (cnt_q == CNT_LAST);

  // A trigger already held across reset must be seen released before a
  // rising edge is reported, so arming waits for a genuine low sample.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = done_w && sync_w && armed_q;
    armed_d = armed_q | (fill_q[1] & ~sync_w);
    if (sync_w != level_q) begin
      if (done_w) begin
        level_d = sync_w;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

`default_nettype wire

// File: rtl/gun_hit_detect.sv
// ------------------------------------------------------------------
// gun_hit_detect: light-gun shot sequencer (black frame, target frame, verdict).
// Define GUN_HIT_DEBUG_EN to add the pd_count_last debug output. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module gun_hit_detect
  import gun_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int HIT_MIN_CYCLES  = HIT_MIN_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic gun_trigger_raw,
  input  logic gun_photodetector_raw,
  input  logic frame_start,
  output logic flash_black,
  output logic flash_target,
  output logic shot,
  output logic hit,
  output logic miss,
  output logic busy
`ifdef GUN_HIT_DEBUG_EN
  ,
  output logic [PD_CNT_W-1:0] pd_count_last
`endif
);

  localparam logic [31:0] HIT_MIN_U = 32'(HIT_MIN_CYCLES);

  gun_state_e          state_q, state_d;
  logic [1:0]          pd_sync_q;
  logic [PD_CNT_W-1:0] pd_cnt_q, pd_cnt_d;
  logic                cheat_q, cheat_d;
  logic                trig_rise_w;
  logic                pd_w;
  logic                pass_w;

  gun_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_trig_debounce (
    .clk   (clk),
    .rst   (rst),
    .raw_i (gun_trigger_raw),
    .rise_o(trig_rise_w)
  );

  assign pd_w   = pd_sync_q[1];
  assign pass_w = (32'(pd_cnt_q) >= HIT_MIN_U) && !cheat_q;

  always_comb begin
    state_d      = state_q;
    pd_cnt_d     = pd_cnt_q;
    cheat_d      = cheat_q;
    shot         = 1'b0;
    flash_black  = 1'b0;
    flash_target = 1'b0;
    hit          = 1'b0;
    miss         = 1'b0;
    busy         = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (trig_rise_w) begin
          shot    = 1'b1;
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (frame_start) state_d = BLACK;
      end
      BLACK: begin
        flash_black = 1'b1;
        if (pd_w) cheat_d = 1'b1;
        if (frame_start) begin
          state_d  = TARGET;
          pd_cnt_d = '0;
        end
      end
      TARGET: begin
        flash_target = 1'b1;
        if (pd_w && (pd_cnt_q != '1)) pd_cnt_d = pd_cnt_q + 1'b1;
        if (frame_start) state_d = RESULT;
      end
      RESULT: begin
        hit     = pass_w;
        miss    = !pass_w;
        cheat_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pd_sync_q <= '0;
      pd_cnt_q  <= '0;
      cheat_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pd_sync_q <= {pd_sync_q[0], gun_photodetector_raw};
      pd_cnt_q  <= pd_cnt_d;
      cheat_q   <= cheat_d;
    end
  end

`ifdef GUN_HIT_DEBUG_EN
  logic [PD_CNT_W-1:0] pd_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pd_last_q <= '0;
    end else if (state_q == RESULT) begin
      pd_last_q <= pd_cnt_q;
    end
  end

  assign pd_count_last = pd_last_q;
`endif

endmodule

`default_nettype wire
